// File: rtl/fp_pkg.sv
// Shared constants, class encodings and FSM states for the FP unpack/align
// front end and the normalizer that consumes its aligned mantissas.
package fp_pkg;

    localparam int BIAS      = 127;
    localparam int MAX_SHIFT = 26;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = FRAC_W + 1;
    localparam int MANT_AL_W = MANT_W + 2;
    localparam int SHIFT_W   = 5;
    localparam int EXP_RES_W = 9;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'b00,
        CLS_NORM = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ALIGN = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/fp_unpack_align_if.sv
// Operand-pair handshake and unpacked/aligned result bundle.
interface fp_unpack_align_if;
    import fp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  OP_input;
    logic [31:0]           A;
    logic [31:0]           B;
    logic                  out_valid;
    logic                  out_ready;
    logic                  Signo_a;
    logic                  Signo_b;
    logic                  Signo_mul;
    logic [EXP_W-1:0]      Exp_comun;
    logic [MANT_AL_W-1:0]  Mant_a_al;
    logic [MANT_AL_W-1:0]  Mant_b_al;
    logic [EXP_RES_W-1:0]  Exp_resul;
    logic [MANT_W-1:0]     Mant_a;
    logic [MANT_W-1:0]     Mant_b;
    logic [1:0]            Clase_a;
    logic [1:0]            Clase_b;
    logic                  Swap;

    modport master (
        output in_valid, OP_input, A, B, out_ready,
        input  in_ready, out_valid, Signo_a, Signo_b, Signo_mul, Exp_comun,
               Mant_a_al, Mant_b_al, Exp_resul, Mant_a, Mant_b,
               Clase_a, Clase_b, Swap
    );

    modport slave (
        input  in_valid, OP_input, A, B, out_ready,
        output in_ready, out_valid, Signo_a, Signo_b, Signo_mul, Exp_comun,
               Mant_a_al, Mant_b_al, Exp_resul, Mant_a, Mant_b,
               Clase_a, Clase_b, Swap
    );

endinterface

// File: rtl/fp_field_split.sv
// Splits one single-precision word into sign/exponent/fraction and classifies
// it; denormals are flushed so their hidden bit and fraction read as zero.
module fp_field_split
    import fp_pkg::*;
(
    input  logic [31:0]       op_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [FRAC_W-1:0] frac_o,
    output logic [MANT_W-1:0] mant_o,
    output class_e            class_o
);

    logic expZero;
    logic expOnes;
    logic rawFracZero;

    assign sign_o      = op_i[31];
    assign exp_o       = op_i[30:23];
    assign expZero     = (exp_o == '0);
    assign expOnes     = (exp_o == '1);
    assign rawFracZero = (op_i[22:0] == '0);
    assign frac_o      = expZero ? '0 : op_i[22:0];
    assign mant_o      = {~expZero, frac_o};

    always_comb begin
        class_o = CLS_NORM;
        if (expZero) begin
            class_o = CLS_ZERO;
        end else if (expOnes) begin
            class_o = rawFracZero ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_unpack_align.sv
// Unpacks an operand pair and prepares it for add (exponent alignment with a
// sticky bit, one shift per cycle) or multiply (exponent sum, raw mantissas).
module fp_unpack_align
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fp_unpack_align_if.slave bus
);

    logic              signA, signB;
    logic [EXP_W-1:0]  expA, expB;
    logic [FRAC_W-1:0] fracA, fracB;
    logic [MANT_W-1:0] mantA, mantB;
    class_e            classA, classB;

    fp_field_split uSplitA (
        .op_i   (bus.A),
        .sign_o (signA),
        .exp_o  (expA),
        .frac_o (fracA),
        .mant_o (mantA),
        .class_o(classA)
    );

    fp_field_split uSplitB (
        .op_i   (bus.B),
        .sign_o (signB),
        .exp_o  (expB),
        .frac_o (fracB),
        .mant_o (mantB),
        .class_o(classB)
    );

    logic                 swap_d;
    logic [EXP_W-1:0]     expDiff;
    logic [SHIFT_W-1:0]   shift_d;
    logic [9:0]           expSum;
    logic                 anyZero;
    logic [EXP_RES_W-1:0] expResul_d;

    // Swap is only meaningful on the add path; a multiply keeps A in the "a" slot.
    assign swap_d     = ~bus.OP_input &
                        ((expB > expA) || ((expB == expA) && (fracB > fracA)));
    assign expDiff    = swap_d ? (expB - expA) : (expA - expB);
    assign shift_d    = bus.OP_input ? '0 :
                        (expDiff > 8'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : expDiff[SHIFT_W-1:0];
    assign expSum     = {2'b00, expA} + {2'b00, expB} - 10'(BIAS);
    assign anyZero    = (classA == CLS_ZERO) || (classB == CLS_ZERO);
    assign expResul_d = (anyZero || expSum[9]) ? '0 : expSum[EXP_RES_W-1:0];

    state_e               state_q;
    logic [SHIFT_W-1:0]   cnt_q;
    logic                 inReady_q, outValid_q;
    logic                 signoA_q, signoB_q, signoMul_q, swap_q;
    logic [EXP_W-1:0]     expComun_q;
    logic [MANT_AL_W-1:0] mantAAl_q, mantBAl_q;
    logic [EXP_RES_W-1:0] expResul_q;
    logic [MANT_W-1:0]    mantA_q, mantB_q;
    logic [1:0]           claseA_q, claseB_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            signoA_q   <= 1'b0;
            signoB_q   <= 1'b0;
            signoMul_q <= 1'b0;
            swap_q     <= 1'b0;
            expComun_q <= '0;
            mantAAl_q  <= '0;
            mantBAl_q  <= '0;
            expResul_q <= '0;
            mantA_q    <= '0;
            mantB_q    <= '0;
            claseA_q   <= '0;
            claseB_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= ST_ALIGN;
                        inReady_q  <= 1'b0;
                        cnt_q      <= shift_d;
                        swap_q     <= swap_d;
                        signoA_q   <= swap_d ? signB : signA;
                        signoB_q   <= swap_d ? signA : signB;
                        signoMul_q <= signA ^ signB;
                        expComun_q <= swap_d ? expB : expA;
                        mantAAl_q  <= swap_d ? {mantB, 2'b00} : {mantA, 2'b00};
                        mantBAl_q  <= swap_d ? {mantA, 2'b00} : {mantB, 2'b00};
                        expResul_q <= expResul_d;
                        mantA_q    <= anyZero ? '0 : mantA;
                        mantB_q    <= anyZero ? '0 : mantB;
                        claseA_q   <= classA;
                        claseB_q   <= classB;
                    end
                end
                ST_ALIGN: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_DONE;
                        outValid_q <= 1'b1;
                    end else begin
                        // Bit 0 accumulates everything that falls off the guard position.
                        mantBAl_q <= {1'b0, mantBAl_q[MANT_AL_W-1:2], mantBAl_q[1] | mantBAl_q[0]};
                        cnt_q     <= cnt_q - 5'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= ST_IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.Signo_a   = signoA_q;
    assign bus.Signo_b   = signoB_q;
    assign bus.Signo_mul = signoMul_q;
    assign bus.Exp_comun = expComun_q;
    assign bus.Mant_a_al = mantAAl_q;
    assign bus.Mant_b_al = mantBAl_q;
    assign bus.Exp_resul = expResul_q;
    assign bus.Mant_a    = mantA_q;
    assign bus.Mant_b    = mantB_q;
    assign bus.Clase_a   = claseA_q;
    assign bus.Clase_b   = claseB_q;
    assign bus.Swap      = swap_q;

endmodule

// File: tb/tb_fp_unpack_align.sv
// Scoreboard bench for fp_unpack_align: a reference model predicts every
// output field and the latency of each accepted operand pair.
module tb_fp_unpack_align;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   acceptCycle = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    fp_unpack_align_if bus ();

    fp_unpack_align dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        sa, sb, sm, sw;
        logic [7:0]  ec;
        logic [25:0] mal, mbl;
        logic [8:0]  er;
        logic [23:0] ma, mb;
        logic [1:0]  ca, cb;
        int          lat;
    } expT;

    expT sbQ[$];

    function automatic logic [1:0] classOf(input logic [31:0] x);
        if (x[30:23] == 8'd0)   return 2'b00;
        if (x[30:23] == 8'hFF)  return (x[22:0] == 23'd0) ? 2'b10 : 2'b11;
        return 2'b01;
    endfunction

    // Independent reference: alignment done as one wide shift plus OR-reduced sticky.
    function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic op);
        expT e;
        int ea, eb, sh, sum;
        logic [22:0] fa, fb;
        logic [23:0] mA, mB;
        logic [25:0] wide, lost;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = (ea == 0) ? 23'd0 : a[22:0];
        fb = (eb == 0) ? 23'd0 : b[22:0];
        mA = {(ea != 0), fa};
        mB = {(eb != 0), fb};
        e.ca = classOf(a);
        e.cb = classOf(b);
        e.sm = a[31] ^ b[31];
        e.sw = !op && ((eb > ea) || (eb == ea && fb > fa));
        e.sa = e.sw ? b[31] : a[31];
        e.sb = e.sw ? a[31] : b[31];
        e.ec = e.sw ? b[30:23] : a[30:23];
        e.mal = e.sw ? {mB, 2'b00} : {mA, 2'b00};
        wide  = e.sw ? {mA, 2'b00} : {mB, 2'b00};
        sh = op ? 0 : ((ea > eb) ? ea - eb : eb - ea);
        if (sh > 26) sh = 26;
        lost = wide & ((26'd1 << sh) - 26'd1);
        e.mbl = wide >> sh;
        e.mbl[0] = e.mbl[0] | (|lost);
        sum = ea + eb - 127;
        if (e.ca == 2'b00 || e.cb == 2'b00) begin
            e.er = 9'd0;
            e.ma = 24'd0;
            e.mb = 24'd0;
        end else begin
            e.er = (sum < 0) ? 9'd0 : 9'(sum);
            e.ma = mA;
            e.mb = mB;
        end
        e.lat = sh + 1;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checkOutput("acceptTimeout", 64'd0, 64'd1);
        end else begin
            bus.A = a;
            bus.B = b;
            bus.OP_input = op;
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            acceptCycle = cycle;
            sbQ.push_back(model(a, b, op));
        end
    endtask

    task automatic collectOutput(input int holdCycles);
        expT e;
        int guard = 0;
        if (sbQ.size() == 0) begin
            checkOutput("emptyQueue", 64'd0, 64'd1);
            return;
        end
        e = sbQ.pop_front();
        while (!bus.out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("outValid", 64'(bus.out_valid), 64'd1);
        checkOutput("latency", 64'(cycle - acceptCycle), 64'(e.lat));
        checkOutput("inReadyDone", 64'(bus.in_ready), 64'd0);
        checkOutput("Signo_a", 64'(bus.Signo_a), 64'(e.sa));
        checkOutput("Signo_b", 64'(bus.Signo_b), 64'(e.sb));
        checkOutput("Signo_mul", 64'(bus.Signo_mul), 64'(e.sm));
        checkOutput("Swap", 64'(bus.Swap), 64'(e.sw));
        checkOutput("Exp_comun", 64'(bus.Exp_comun), 64'(e.ec));
        checkOutput("Mant_a_al", 64'(bus.Mant_a_al), 64'(e.mal));
        checkOutput("Mant_b_al", 64'(bus.Mant_b_al), 64'(e.mbl));
        checkOutput("Exp_resul", 64'(bus.Exp_resul), 64'(e.er));
        checkOutput("Mant_a", 64'(bus.Mant_a), 64'(e.ma));
        checkOutput("Mant_b", 64'(bus.Mant_b), 64'(e.mb));
        checkOutput("Clase_a", 64'(bus.Clase_a), 64'(e.ca));
        checkOutput("Clase_b", 64'(bus.Clase_b), 64'(e.cb));
        for (int i = 0; i < holdCycles; i++) begin
            bus.A = 32'h12345678;
            bus.B = 32'h87654321;
            bus.OP_input = 1'b1;
            bus.in_valid = 1'b1;
            @(negedge clk);
            checkOutput("holdValid", 64'(bus.out_valid), 64'd1);
            checkOutput("holdInReady", 64'(bus.in_ready), 64'd0);
            checkOutput("holdMantA_al", 64'(bus.Mant_a_al), 64'(e.mal));
            checkOutput("holdMantB_al", 64'(bus.Mant_b_al), 64'(e.mbl));
            checkOutput("holdExpComun", 64'(bus.Exp_comun), 64'(e.ec));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("releaseValid", 64'(bus.out_valid), 64'd0);
        checkOutput("releaseInReady", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "InReady"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "OutValid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "MantAAl"}, 64'(bus.Mant_a_al), 64'd0);
        checkOutput({tag, "MantBAl"}, 64'(bus.Mant_b_al), 64'd0);
        checkOutput({tag, "ExpComun"}, 64'(bus.Exp_comun), 64'd0);
        checkOutput({tag, "Misc"}, 64'({bus.Signo_a, bus.Signo_b, bus.Signo_mul, bus.Swap,
                                        bus.Exp_resul, bus.Mant_a, bus.Mant_b,
                                        bus.Clase_a, bus.Clase_b}), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int ea, eb;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.OP_input = 1'b0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        collectOutput(0);
        applyStimulus(32'h3F000000, 32'h3F800000, 1'b0);
        collectOutput(0);
        applyStimulus(32'h3F800000, 32'h30800000, 1'b0);
        collectOutput(0);
        applyStimulus(32'h40000000, 32'hC0400000, 1'b1);
        collectOutput(5);
        applyStimulus(32'h00000001, 32'h7FC00000, 1'b1);
        collectOutput(0);
        applyStimulus(32'h3F800000, 32'h00000000, 1'b1);
        collectOutput(0);
        applyStimulus(32'h7F800000, 32'hBF800001, 1'b0);
        collectOutput(0);

        // Abort a long alignment with reset; the aborted pair never completes.
        applyStimulus(32'h3F800000, 32'h30800000, 1'b0);
        void'(sbQ.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h3F800000, 32'h30800000, 1'b0);
        collectOutput(0);

        for (int i = 0; i < 20; i++) begin
            ea = int'($urandom_range(100, 160));
            eb = ea + int'($urandom_range(0, 64)) - 32;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if (i % 5 == 0) rb[30:0] = ra[30:0] ^ 31'(i);
            applyStimulus(ra, rb, 1'($urandom));
            collectOutput(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
